// File: rtl/rx_payload_word_packer_if.sv
// Byte-in / word-out AXI-Stream bundle for the RX payload packer.
// slave  : the packer's view (consumes s_*, produces m_*).
// master : the surrounding logic's view (produces s_*, consumes m_*).
interface rx_payload_word_packer_if;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
  );
endinterface

// File: rtl/rx_payload_word_packer.sv
// Packs decoded RX payload bytes into 32-bit big-endian words with byte keep.
// Frames longer than MAX_WORDS words are cut: the last allowed word is marked
// last, trunc_pulse fires, and the rest of the frame is drained.
module rx_payload_word_packer #(
  parameter logic [15:0] MAX_WORDS = 16'd128,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic                     axi_tclk,
  input  logic                     axi_tresetn,
  input  logic                     enable,
  rx_payload_word_packer_if.slave  bus,
  output logic [15:0]              frames_out,
  output logic                     trunc_pulse
);

  typedef enum logic [1:0] {IDLE, ACCUM, DROP} state_t;

  localparam logic [15:0] LAST_WORD = MAX_WORDS - 16'd1;

  state_t          r_state;
  logic [1:0]      r_lane;
  logic [15:0]     r_wcnt;
  logic [3:0][7:0] r_acc;
  logic [31:0]     r_mdata;
  logic [3:0]      r_mkeep;
  logic            r_mvalid;
  logic            r_mlast;
  logic            r_trunc;
  logic [15:0]     r_frames;

  logic            w_ready;
  logic            w_accept;
  logic            w_pack;
  logic            w_done;
  logic            w_trunc;
  logic [1:0]      w_lane;
  logic [31:0]     w_word;
  logic [3:0]      w_keep;

  // Accept bytes whenever the output register is free (or draining); held low in reset.
  always_comb begin
    w_ready = 1'b0;
    if (axi_tresetn)
      w_ready = (r_state == DROP) ? 1'b1 : (!r_mvalid || bus.m_tready);
  end

  assign w_accept = bus.s_tvalid && w_ready;
  // enable only matters on the first byte; ACCUM keeps packing regardless.
  assign w_pack   = w_accept && ((r_state == ACCUM) || (r_state == IDLE && enable));
  assign w_lane   = (r_state == ACCUM) ? r_lane : 2'd0;
  assign w_done   = w_pack && ((w_lane == 2'd3) || bus.s_tlast);
  // Hitting the word limit without tlast means the frame is oversize.
  assign w_trunc  = w_done && !bus.s_tlast && (r_wcnt == LAST_WORD);

  // Assemble the completing word: earlier lanes from the accumulator, the current
  // byte in its lane, PAD_BYTE in every lane not yet reached.
  always_comb begin
    w_word = {4{PAD_BYTE}};
    w_keep = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) < w_lane) begin
        w_word[31-8*k -: 8] = r_acc[k];
        w_keep[3-k]         = 1'b1;
      end else if (2'(k) == w_lane) begin
        w_word[31-8*k -: 8] = bus.s_tdata;
        w_keep[3-k]         = 1'b1;
      end
    end
  end

  // Frame FSM, lane/word tracking, output word register and frame counter.
  always_ff @(posedge axi_tclk) begin
    if (!axi_tresetn) begin
      r_state  <= IDLE;
      r_lane   <= 2'd0;
      r_wcnt   <= 16'd0;
      r_acc    <= '0;
      r_mdata  <= 32'd0;
      r_mkeep  <= 4'd0;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_trunc  <= 1'b0;
      r_frames <= 16'd0;
    end else begin
      r_trunc <= 1'b0;

      // Handshake retires the held word; a word loaded below overrides m_tvalid.
      if (r_mvalid && bus.m_tready) begin
        r_mvalid <= 1'b0;
        if (r_mlast) r_frames <= r_frames + 16'd1;
      end

      if (w_done) begin
        r_mdata  <= w_word;
        r_mkeep  <= w_keep;
        r_mlast  <= bus.s_tlast || w_trunc;
        r_mvalid <= 1'b1;
        r_trunc  <= w_trunc;
      end

      if (w_pack) begin
        r_acc[w_lane] <= bus.s_tdata;
        if (w_done) begin
          r_lane <= 2'd0;
          if (bus.s_tlast) begin
            r_wcnt  <= 16'd0;
            r_state <= IDLE;
          end else if (w_trunc) begin
            r_wcnt  <= 16'd0;
            r_state <= DROP;
          end else begin
            r_wcnt  <= r_wcnt + 16'd1;
            r_state <= ACCUM;
          end
        end else begin
          r_lane  <= w_lane + 2'd1;
          r_state <= ACCUM;
        end
      end else if (w_accept) begin
        // Disabled frame start or drain: discard until tlast.
        r_state <= bus.s_tlast ? IDLE : DROP;
      end
    end
  end

  assign bus.s_tready = w_ready;
  assign bus.m_tdata  = r_mdata;
  assign bus.m_tkeep  = r_mkeep;
  assign bus.m_tvalid = r_mvalid;
  assign bus.m_tlast  = r_mlast;
  assign frames_out   = r_frames;
  assign trunc_pulse  = r_trunc;

endmodule

// File: tb/tb_rx_payload_word_packer.sv
// Bench for rx_payload_word_packer with MAX_WORDS=2 so truncation is cheap to reach.
module tb_rx_payload_word_packer;
  localparam logic [15:0] MAXW = 16'd2;
  localparam logic [7:0]  PAD  = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] frames_out;
  logic        trunc_pulse;

  rx_payload_word_packer_if bus();

  rx_payload_word_packer #(.MAX_WORDS(MAXW), .PAD_BYTE(PAD)) dut (
    .axi_tclk(clk), .axi_tresetn(rst_n), .enable(enable),
    .bus(bus.slave), .frames_out(frames_out), .trunc_pulse(trunc_pulse));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ntrunc = 0;
  int exp_trunc = 0;
  int nfr = 0;
  bit done = 1'b0;
  logic [36:0] got[$];
  logic [36:0] exp_q[$];

  // Collect every output handshake and every truncation pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_tvalid && bus.m_tready) got.push_back({bus.m_tdata, bus.m_tkeep, bus.m_tlast});
      if (trunc_pulse) ntrunc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Drive one frame of bytes base, base+1, ...; optionally flip enable after byte 0.
  task automatic send(input logic en, input int len, input logic [7:0] base,
                      input bit flip, input bit gaps);
    bit ok;
    int n;
    enable = en;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = 8'(base + 8'(i));
      bus.s_tlast  = (i == len - 1);
      if (flip && i == 1) enable = !en;
      n = 0;
      do begin
        @(negedge clk); ok = bus.s_tready;
        @(posedge clk); #1;
        n++;
      end while (!ok && n < 200);
      if (!ok) begin
        total++; bad++;
        $display("FAIL send_timeout: byte %0d got no s_tready, required within 200 cycles", i);
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic drain();
    bus.m_tready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Reference: split the frame into 4-byte big-endian words, cap at MAXW words.
  function automatic void model(input logic en, input int len, input logic [7:0] base);
    int nw;
    logic [31:0] w;
    logic [3:0] k;
    if (!en) return;
    nw = (len + 3) / 4;
    if (nw > int'(MAXW)) begin
      nw = int'(MAXW);
      exp_trunc++;
    end
    for (int j = 0; j < nw; j++) begin
      w = {4{PAD}};
      k = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        if (4*j + b < len) begin
          w[31-8*b -: 8] = 8'(base + 8'(4*j + b));
          k[3-b] = 1'b1;
        end
      end
      exp_q.push_back({w, k, (j == nw - 1)});
    end
  endfunction

  typedef struct {
    logic        en;
    int          len;
    logic [7:0]  base;
    int          nw;
    logic [31:0] w0; logic [3:0] k0; logic l0;
    logic [31:0] w1; logic [3:0] k1; logic l1;
    int          tr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int t0;
    int nmin;
    logic        r_en;
    int          r_len;
    logic [7:0]  r_base;

    tbl[0] = '{1'b1,  8, 8'h01, 2, 32'h01020304, 4'hF, 1'b0, 32'h05060708, 4'hF, 1'b1, 0};
    tbl[1] = '{1'b1,  6, 8'hAA, 2, 32'hAAABACAD, 4'hF, 1'b0, 32'hAEAF0000, 4'hC, 1'b1, 0};
    tbl[2] = '{1'b1,  1, 8'h5A, 1, 32'h5A000000, 4'h8, 1'b1, 32'h0,        4'h0, 1'b0, 0};
    tbl[3] = '{1'b1, 12, 8'h01, 2, 32'h01020304, 4'hF, 1'b0, 32'h05060708, 4'hF, 1'b1, 1};
    tbl[4] = '{1'b1,  4, 8'h10, 1, 32'h10111213, 4'hF, 1'b1, 32'h0,        4'h0, 1'b0, 0};
    tbl[5] = '{1'b0,  8, 8'h20, 0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 0};
    tbl[6] = '{1'b1,  3, 8'h30, 1, 32'h30313200, 4'hE, 1'b1, 32'h0,        4'h0, 1'b0, 0};

    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.s_tdata = 8'h00; bus.m_tready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_m_tlast",  bus.m_tlast, 0);
    chk("rst_m_tkeep",  bus.m_tkeep, 0);
    chk("rst_m_tdata",  bus.m_tdata, 0);
    chk("rst_frames",   frames_out, 0);
    chk("rst_trunc",    trunc_pulse, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      t0 = ntrunc;
      got.delete();
      send(tbl[i].en, tbl[i].len, tbl[i].base, !tbl[i].en, 1'b0);
      drain();
      chk($sformatf("v%0d_count", i), got.size(), tbl[i].nw);
      if (got.size() > 0) chk($sformatf("v%0d_w0", i), got[0], {tbl[i].w0, tbl[i].k0, tbl[i].l0});
      if (got.size() > 1) chk($sformatf("v%0d_w1", i), got[1], {tbl[i].w1, tbl[i].k1, tbl[i].l1});
      chk($sformatf("v%0d_trunc", i), ntrunc - t0, tbl[i].tr);
      if (tbl[i].en) nfr++;
      chk($sformatf("v%0d_frames", i), frames_out, nfr);
    end

    // Word appears the cycle after its completing byte.
    got.delete();
    send(1'b1, 4, 8'h40, 1'b0, 1'b0);
    chk("lat_valid", bus.m_tvalid, 1);
    chk("lat_data",  bus.m_tdata, 32'h40414243);
    chk("lat_last",  bus.m_tlast, 1);
    drain();
    nfr++;

    // Backpressure: held word stays stable and input stalls for 10 cycles.
    got.delete();
    bus.m_tready = 1'b0;
    send(1'b1, 4, 8'h50, 1'b0, 1'b0);
    fork
      send(1'b1, 4, 8'h60, 1'b0, 1'b0);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk($sformatf("bp_s_tready_%0d", c), bus.s_tready, 0);
          chk($sformatf("bp_m_tdata_%0d", c), bus.m_tdata, 32'h50515253);
        end
        @(posedge clk); #1;
        bus.m_tready = 1'b1;
      end
    join
    drain();
    nfr += 2;
    chk("bp_count", got.size(), 2);
    if (got.size() > 0) chk("bp_w0", got[0], {32'h50515253, 4'hF, 1'b1});
    if (got.size() > 1) chk("bp_w1", got[1], {32'h60616263, 4'hF, 1'b1});
    chk("bp_frames", frames_out, nfr);

    // Reset after 3 bytes of a frame: partial word lost.
    got.delete();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_tvalid = 1'b1; bus.s_tdata = 8'(8'h80 + 8'(i)); bus.s_tlast = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_tvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_m_tvalid", bus.m_tvalid, 0);
    chk("mr_m_tdata",  bus.m_tdata, 0);
    chk("mr_m_tkeep",  bus.m_tkeep, 0);
    chk("mr_frames",   frames_out, 0);
    rst_n = 1'b1;
    nfr = 0;
    send(1'b1, 4, 8'h70, 1'b0, 1'b0);
    drain();
    nfr++;
    chk("mr_count", got.size(), 1);
    if (got.size() > 0) chk("mr_w0", got[0], {32'h70717273, 4'hF, 1'b1});
    chk("mr_frames_after", frames_out, nfr);

    // Randomized frames with random gaps and downstream stalls.
    got.delete();
    exp_q.delete();
    t0 = ntrunc;
    exp_trunc = 0;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          r_en   = ($urandom_range(0, 4) != 0);
          r_len  = $urandom_range(1, 13);
          r_base = 8'($urandom);
          model(r_en, r_len, r_base);
          if (r_en) nfr++;
          send(r_en, r_len, r_base, 1'($urandom_range(0, 1)), 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.m_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    chk("rnd_count", got.size(), exp_q.size());
    nmin = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) chk($sformatf("rnd_w%0d", i), got[i], exp_q[i]);
    chk("rnd_trunc", ntrunc - t0, exp_trunc);
    chk("rnd_frames", frames_out, 16'(nfr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
